ysyx_25030085_regfile_sb: RTL and testbench

//  Parametrised GPR file with load scoreboard for the NPC core. Provides 2 async read ports and 1 arch

---
 rtl/ysyx_25030085_regfile_sb.sv | 103 ++++++++++
 tb/tb_ysyx_25030085_regfile_sb.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ysyx_25030085_regfile_sb.sv
// ysyx_25030085_regfile_sb: GPR file with in-order load scoreboard (busy bits + tag FIFO); optional REGFILE_BYPASS_EN forwarding
// Ports: clk/rst (async active-high); rs1/rs2 async reads with busy flags; wb_* arch write-back (ALU/PC+4/IMM);
// ld_issue_* load issue handshake; ld_resp_* in-order load return handshake; stall hazard flag; ld_count outstanding loads.
module ysyx_25030085_regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int LD_DEPTH = 4,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wb_en,
  input  logic [1:0]      wb_sel,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            ld_issue_valid,
  input  logic [AW-1:0]   ld_issue_rd,
  output logic            ld_issue_ready,
  input  logic            ld_resp_valid,
  input  logic [XLEN-1:0] ld_resp_data,
  output logic            ld_resp_ready,
  output logic            stall,
  output logic [AW:0]     ld_count
);
  localparam int PW = $clog2(LD_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(LD_DEPTH);
  logic [XLEN-1:0] gpr_q [NREG];
  logic [XLEN-1:0] gpr_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW-1:0]   fifo_q [LD_DEPTH];
  logic [AW-1:0]   fifo_d [LD_DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            iss, rsp, wb_do;
  logic [AW-1:0]   tag;
  logic [XLEN-1:0] wb_val;
  assign ld_issue_ready = (cnt_q < DEPTH) & ~busy_q[ld_issue_rd];
  assign ld_resp_ready  = cnt_q != '0;
  assign ld_count       = cnt_q;
  assign iss   = ld_issue_valid & ld_issue_ready;
  assign rsp   = ld_resp_valid & ld_resp_ready;
  assign tag   = fifo_q[rptr_q];
  assign wb_do = wb_en & (wb_sel != 2'b01) & (rd_addr != '0) & ~busy_q[rd_addr];
  assign wb_val = wb_sel[0] ? imm : wb_sel[1] ? pc + XLEN'(4) : alu_result;
  // The wb hazard term uses registered busy in both builds so a suppressed write always shows as a stall.
  assign stall = rs1_busy | rs2_busy | (wb_en & busy_q[rd_addr]);
`ifdef REGFILE_BYPASS_EN
  assign rs1_data = (rs1_addr == '0) ? '0 : (rsp && tag == rs1_addr) ? ld_resp_data :
                    (wb_do && rd_addr == rs1_addr) ? wb_val : gpr_q[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0 : (rsp && tag == rs2_addr) ? ld_resp_data :
                    (wb_do && rd_addr == rs2_addr) ? wb_val : gpr_q[rs2_addr];
  assign rs1_busy = busy_q[rs1_addr] & ~(rsp && tag == rs1_addr);
  assign rs2_busy = busy_q[rs2_addr] & ~(rsp && tag == rs2_addr);
`else
  assign rs1_data = gpr_q[rs1_addr];
  assign rs2_data = gpr_q[rs2_addr];
  assign rs1_busy = busy_q[rs1_addr];
  assign rs2_busy = busy_q[rs2_addr];
`endif
  // A popping tag is still busy here, so an issue to it is blocked; clear-then-set ordering never conflicts.
  always_comb begin
    gpr_d  = gpr_q;
    busy_d = busy_q;
    fifo_d = fifo_q;
    if (wb_do) gpr_d[rd_addr] = wb_val;
    if (rsp) begin
      if (tag != '0) gpr_d[tag] = ld_resp_data;
      busy_d[tag] = 1'b0;
    end
    if (iss) begin
      fifo_d[wptr_q] = ld_issue_rd;
      if (ld_issue_rd != '0) busy_d[ld_issue_rd] = 1'b1;
    end
    wptr_d = wptr_q + PW'(iss);
    rptr_d = rptr_q + PW'(rsp);
    cnt_d  = cnt_q + (AW+1)'(iss) - (AW+1)'(rsp);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
      for (int i = 0; i < LD_DEPTH; i++) fifo_q[i] <= '0;
      busy_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      gpr_q  <= gpr_d;
      fifo_q <= fifo_d;
      busy_q <= busy_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_ysyx_25030085_regfile_sb.sv
// tb_ysyx_25030085_regfile_sb: scoreboard bench for the regfile with load scoreboard
module tb_ysyx_25030085_regfile_sb;
  logic clk = 0, rst = 1;
  logic [4:0] rs1_addr = 0, rs2_addr = 0, rd_addr = 0, ld_issue_rd = 0;
  logic [31:0] rs1_data, rs2_data, alu_result = 0, pc = 0, imm = 0, ld_resp_data = 0;
  logic rs1_busy, rs2_busy, wb_en = 0, ld_issue_valid = 0, ld_issue_ready;
  logic ld_resp_valid = 0, ld_resp_ready, stall;
  logic [1:0] wb_sel = 0;
  logic [5:0] ld_count;
  int n_chk = 0, n_err = 0;
  typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
  ent_t sb [$];
  ent_t cur;
  always #5 clk = ~clk;
  ysyx_25030085_regfile_sb dut (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .wb_en(wb_en), .wb_sel(wb_sel),
    .rd_addr(rd_addr), .alu_result(alu_result), .pc(pc), .imm(imm), .ld_issue_valid(ld_issue_valid),
    .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready), .ld_resp_valid(ld_resp_valid),
    .ld_resp_data(ld_resp_data), .ld_resp_ready(ld_resp_ready), .stall(stall), .ld_count(ld_count));
  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", t, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
    wb_en = 0; ld_issue_valid = 0; ld_resp_valid = 0;
  endtask
  task automatic wb(input logic [1:0] s, input logic [4:0] rd, input logic [31:0] a, p, i);
    wb_en = 1; wb_sel = s; rd_addr = rd; alu_result = a; pc = p; imm = i;
    tick();
  endtask
  task automatic issue(input logic [4:0] rd);
    ent_t e;
    e.rd = rd; e.d = $urandom;
    sb.push_back(e);
    ld_issue_valid = 1; ld_issue_rd = rd;
  endtask
  task automatic resp;
    cur = sb.pop_front();
    ld_resp_valid = 1; ld_resp_data = cur.d;
  endtask
  task automatic rd1(input string t, input logic [4:0] a, input logic [31:0] exp);
    rs1_addr = a; #1;
    chk(t, rs1_data, exp);
  endtask
  initial begin
    #2;
    rs1_addr = 5; rs2_addr = 0; #1;
    chk("rst_rs1", rs1_data, 0);
    chk("rst_cnt", ld_count, 0);
    chk("rst_rready", ld_resp_ready, 0);
    @(negedge clk); rst = 0;
    tick();
    chk("rel_iready", ld_issue_ready, 1);
    wb(2'b00, 5, 32'h1234, 0, 0);
    rd1("alu_x5", 5, 32'h0000_1234);
    wb(2'b00, 0, 32'hFFFF, 0, 0);
    rd1("x0_wr", 0, 0);
    wb(2'b10, 1, 0, 32'hFFFF_FFFC, 0);
    rd1("pc4_wrap", 1, 0);
    wb(2'b11, 2, 0, 0, 32'hABCD_E000);
    rd1("imm_x2", 2, 32'hABCD_E000);
    wb(2'b01, 2, 32'h5, 32'h5, 32'h5);
    rd1("sel01_nop", 2, 32'hABCD_E000);
    for (int i = 7; i <= 10; i++) begin
      issue(5'(i)); tick();
    end
    chk("full_cnt", ld_count, 4);
    ld_issue_rd = 20; #1;
    chk("full_iready", ld_issue_ready, 0);
    for (int i = 0; i < 4; i++) begin
      resp(); tick();
      rd1("ld_data", cur.rd, cur.d);
    end
    chk("drain_cnt", ld_count, 0);
    issue(3); tick();
    rs1_addr = 3; wb_en = 1; wb_sel = 2'b00; rd_addr = 3; alu_result = 32'h999; #1;
    chk("raw_stall", stall, 1);
    chk("raw_busy", rs1_busy, 1);
    tick();
    rd1("wb_busy_supp", 3, 0);
    ld_issue_valid = 1; ld_issue_rd = 3; #1;
    chk("waw_block", ld_issue_ready, 0);
    ld_issue_valid = 0;
    resp(); #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_data", rs1_data, cur.d);
    chk("byp_stall", stall, 0);
`else
    chk("nobyp_data", rs1_data, 0);
    chk("nobyp_stall", stall, 1);
`endif
    tick();
    chk("resp_data", rs1_data, cur.d);
    chk("resp_stall", stall, 0);
    issue(4); tick();
    resp(); ld_issue_valid = 1; ld_issue_rd = 4; #1;
    chk("pop_iss_block", ld_issue_ready, 0);
    tick();
    chk("pop_iss_cnt", ld_count, 0);
    rd1("pop_data", 4, cur.d);
    ld_issue_rd = 4; #1;
    chk("pop_iss_retry", ld_issue_ready, 1);
    issue(0); tick();
    chk("x0_ld_cnt", ld_count, 1);
    rs1_addr = 0; #1;
    chk("x0_busy", rs1_busy, 0);
    resp(); tick();
    rd1("x0_ld_data", 0, 0);
    ld_resp_valid = 1; ld_resp_data = 32'hDEAD; #1;
    chk("empty_rready", ld_resp_ready, 0);
    tick();
    chk("empty_cnt", ld_count, 0);
    issue(11); tick();
    resp(); issue(12); tick();
    chk("overlap_cnt", ld_count, 1);
    rd1("overlap_x11", 11, cur.d);
    resp(); tick();
    rd1("overlap_x12", 12, cur.d);
    issue(13); tick();
    issue(14); tick();
    chk("pre_rst_cnt", ld_count, 2);
    #2 rst = 1; #1;
    sb.delete();
    rs1_addr = 13; #1;
    chk("mid_rst_cnt", ld_count, 0);
    chk("mid_rst_rready", ld_resp_ready, 0);
    chk("mid_rst_busy", rs1_busy, 0);
    rd1("mid_rst_gpr", 5, 0);
    @(negedge clk); rst = 0;
    tick();
    chk("post_rst_iready", ld_issue_ready, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
